// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared widths and bit-index type for the SPI slave slice.
package spi_slave_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int CNT_W = 3;
  typedef logic [CNT_W-1:0] bitIdx_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI bus plus the parallel words exchanged with the slave.
interface spi_slave_if #(parameter int DATA_W = spi_slave_pkg::DEF_DATA_W);
  logic CS;
  logic MOSI;
  logic MISO;
  logic [DATA_W-1:0] slaveDataToSend;
  logic [DATA_W-1:0] slaveDataReceived;
  modport master(output CS, MOSI, slaveDataToSend, input MISO, slaveDataReceived);
  modport slave(input CS, MOSI, slaveDataToSend, output MISO, slaveDataReceived);
endinterface

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: wrapping bit-slot index, advanced on SCLK rise, cleared by reset or deselect.
module spi_bit_counter
  import spi_slave_pkg::*;
(
  input  logic    SCLK,
  input  logic    reset,
  input  logic    CS,
  output bitIdx_t cnt
);
  always_ff @(posedge SCLK or negedge reset or posedge CS)
    if (!reset) cnt <= '0;
    else if (CS) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: LSB-first SPI slave, MISO launched on SCLK fall, MOSI captured on SCLK rise.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO while deselected or in reset.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input logic        SCLK,
  input logic        reset,
  spi_slave_if.slave bus
);
  localparam bitIdx_t LAST = bitIdx_t'(DATA_W - 1);
  bitIdx_t cnt;
  logic [DATA_W-1:0] txReg;
  logic [DATA_W-1:0] rxReg;
  logic misoReg;
  spi_bit_counter u_cnt (
    .SCLK (SCLK),
    .reset(reset),
    .CS   (bus.CS),
    .cnt  (cnt)
  );
  // Slot 0 snapshots the outgoing word so later changes cannot disturb the frame.
  always_ff @(negedge SCLK or negedge reset)
    if (!reset) begin
      txReg <= '0;
      misoReg <= 1'b0;
    end else if (!bus.CS) begin
      txReg <= (cnt == '0) ? bus.slaveDataToSend : txReg;
      misoReg <= (cnt == '0) ? bus.slaveDataToSend[0] : txReg[cnt];
    end
  always_ff @(posedge SCLK or negedge reset or posedge bus.CS)
    if (!reset) rxReg <= '0;
    else if (bus.CS) rxReg <= '0;
    else rxReg[cnt] <= bus.MOSI;
  always_ff @(posedge SCLK or negedge reset)
    if (!reset) bus.slaveDataReceived <= '0;
    else if (!bus.CS && cnt == LAST) bus.slaveDataReceived <= {bus.MOSI, rxReg[DATA_W-2:0]};
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.MISO = (bus.CS || !reset) ? 1'bz : misoReg;
`else
  assign bus.MISO = (bus.CS || !reset) ? 1'b0 : misoReg;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table-driven frames with a scoreboard, plus abort and mid-frame reset sequences.
module tb_spi_slave;
  logic SCLK = 1'b1;
  logic reset = 1'b0;
  int checks = 0;
  int fails = 0;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic IDLE = 1'bz;
`else
  localparam logic IDLE = 1'b0;
`endif
  typedef struct {
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] expRecv;
    logic [7:0] expMaster;
  } vec_t;
  vec_t vecs[4];
  logic [15:0] sb[$];
  logic [15:0] exp;
  logic [7:0] got;
  spi_slave_if #(.DATA_W(8)) bus ();
  spi_slave #(.DATA_W(8)) dut (
    .SCLK (SCLK),
    .reset(reset),
    .bus  (bus.slave)
  );
  always #5 SCLK = ~SCLK;
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic sendBits(input logic [7:0] mo, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge SCLK);
      bus.MOSI = mo[k];
      @(posedge SCLK);
      #1;
    end
  endtask
  task automatic runFrame(input logic [7:0] tx, input logic [7:0] mo, input bit chkMid,
                          input logic [7:0] hold, output logic [7:0] rx);
    bus.slaveDataToSend = tx;
    for (int k = 0; k < 8; k++) begin
      @(negedge SCLK);
      bus.MOSI = mo[k];
      @(posedge SCLK);
      #1;
      rx[k] = bus.MISO;
      if (k == 2) bus.slaveDataToSend = ~tx;
      if (chkMid && k < 7) chk("holdRecv", bus.slaveDataReceived, hold);
    end
  endtask
  initial begin
    bus.CS = 1'b1;
    bus.MOSI = 1'b0;
    bus.slaveDataToSend = '0;
    vecs = '{'{8'h00, 8'h00, 8'h00, 8'h00},
             '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
             '{8'h83, 8'h20, 8'h20, 8'h83},
             '{8'h9A, 8'h7F, 8'h7F, 8'h9A}};
    #2;
    chk("resetRecv", bus.slaveDataReceived, 8'h00);
    chk("resetMiso", {7'b0, bus.MISO}, {7'b0, IDLE});
    @(posedge SCLK);
    #1;
    reset = 1'b1;
    bus.CS = 1'b0;
    foreach (vecs[i]) begin
      sb.push_back({vecs[i].expRecv, vecs[i].expMaster});
      runFrame(vecs[i].tx, vecs[i].mo, 1'b0, 8'h00, got);
      exp = sb.pop_front();
      chk($sformatf("recv%0d", i), bus.slaveDataReceived, exp[15:8]);
      chk($sformatf("masterRx%0d", i), got, exp[7:0]);
    end
    bus.slaveDataToSend = 8'h11;
    sendBits(8'hA5, 4);
    bus.CS = 1'b1;
    #1;
    chk("abortRecv", bus.slaveDataReceived, 8'h7F);
    chk("abortMiso", {7'b0, bus.MISO}, {7'b0, IDLE});
    repeat (3) @(posedge SCLK);
    #1;
    chk("deselRecv", bus.slaveDataReceived, 8'h7F);
    bus.CS = 1'b0;
    sb.push_back({8'h3C, 8'h5A});
    runFrame(8'h5A, 8'h3C, 1'b1, 8'h7F, got);
    exp = sb.pop_front();
    chk("postAbortRecv", bus.slaveDataReceived, exp[15:8]);
    chk("postAbortMaster", got, exp[7:0]);
    bus.slaveDataToSend = 8'hC3;
    sendBits(8'h66, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("midResetRecv", bus.slaveDataReceived, 8'h00);
    chk("midResetMiso", {7'b0, bus.MISO}, {7'b0, IDLE});
    #2;
    reset = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_W, default 8, frame length in bits; the SPI frame format below is defined for DATA_W = 8.
REQ-002 SCLK  input  1  serial clock from master; the single clock of the block; rising and falling edges both used.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 slaveDataToSend  input  DATA_W  parallel word the slave transmits on MISO.
REQ-005 slaveDataReceived  output  DATA_W  last complete word received on MOSI.
REQ-006 CS  input  1  chip select, active-low; 0 = slave selected.
REQ-007 MOSI  input  1  serial data, master to slave.
REQ-008 MISO  output  1  serial data, slave to master.

Function
REQ-009 Bit order SHALL be LSB first in both directions; bit index k of a frame is carried in bit slot k (k = 0..7).
REQ-010 A 3-bit bit index cnt SHALL select the current slot; cnt = 0 marks frame start.
REQ-011 On each SCLK falling edge with CS = 0: if cnt = 0, latch slaveDataToSend into tx_reg and drive MISO = slaveDataToSend[0]; otherwise drive MISO = tx_reg[cnt].
REQ-012 On each SCLK rising edge with CS = 0: store MOSI into rx_reg[cnt]; then cnt increments, wrapping 7 -> 0.
REQ-013 On the rising edge where cnt = 7, slaveDataReceived SHALL update to {MOSI, rx_reg[6:0]} on that same edge (zero extra latency).
REQ-014 slaveDataReceived SHALL hold its value between frame completions; partial frames never alter it.
REQ-015 Frames SHALL run back-to-back with CS held low: the falling edge after a completed frame starts the next frame and re-latches slaveDataToSend.
REQ-016 slaveDataToSend changes during a frame SHALL NOT affect the frame in progress (tx_reg only).
REQ-017 CS = 1 SHALL asynchronously abort any frame: cnt forced to 0, rx_reg partial contents discarded, slaveDataReceived unchanged.
REQ-018 While CS = 1, SCLK edges SHALL be ignored.

Reset
REQ-019 reset = 0 SHALL asynchronously clear cnt, tx_reg, rx_reg and slaveDataReceived to 0 and drive MISO = 0 (or Z per REQ-021).
REQ-020 Reset has priority over CS and SCLK; the first frame after release starts at the first SCLK falling edge with CS = 0.

Configuration
REQ-021 Macro SPI_SLAVE_MISO_TRISTATE_EN: when defined, MISO SHALL be high-impedance whenever CS = 1 or reset = 0; when undefined, MISO SHALL be driven 0 in those conditions.

Structure
REQ-022 Package spi_slave_pkg SHALL hold DATA_W default (8), CNT_W (3) and the bit-index type.
REQ-023 Sub-module spi_bit_counter (3-bit wrapping counter, rising-edge increment, async clear on reset or CS = 1) SHALL be instantiated once; shift/transmit logic stays in spi_slave.

Verification
REQ-024 SCLK period 10, starts high; reset = 0 for 10, then reset = 1, CS = 0; master drives MOSI on falling edges and samples MISO on rising edges, LSB first.
REQ-025 Frame 1: slave 0x00, master 0x00 -> slaveDataReceived = 0x00, master receives 0x00.
REQ-026 Frame 2 back-to-back: slave 0xFF, master 0xFF -> slaveDataReceived = 0xFF, master receives 0xFF.
REQ-027 Frame 3: slave 0x83, master 0x20 -> slaveDataReceived = 0x20, master receives 0x83.
REQ-028 Frame 4: slave 0x9A, master 0x7F -> slaveDataReceived = 0x7F, master receives 0x9A.
REQ-029 Abort: raise CS after 4 bits of master 0xA5, lower CS, send full 0x3C -> slaveDataReceived stays 0x7F until the 8th rising edge of the new frame, then 0x3C; async reset mid-frame -> slaveDataReceived = 0x00 immediately.
